sync_fifo_flags: RTL

Parametrised successor to the team's single-clock FIFO. Adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds and a fill-level output. Also adds write-when-full-with-read pass-through, synchronous flush, and sticky overflow/underflow error flags. Used as the general-purpose buffer between streaming datapath stages and register-programmed control logic.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem_2p.sv | 25 ++
 rtl/sync_fifo_flags.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Smallest n with 2**n >= value; used to cross-check pointer width against depth.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_2p #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [PTR_SIZE-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [PTR_SIZE-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[write_addr] <= write_data;
    end
  end

  assign read_data = mem_q[read_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard/FWFT read modes, threshold flags, fill level,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_SIZE   = 4,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_SIZE:0]     level,
  output logic                  overflow,
  output logic                  underflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (PTR_SIZE != clog2(DEPTH)) begin : g_bad_ptr
    $error("sync_fifo_flags: PTR_SIZE must equal clog2(DEPTH)");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH out of range");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH out of range");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flags: FWFT must be 0 or 1");
  end

  localparam logic [PTR_SIZE:0] LvlDepth = (PTR_SIZE + 1)'(DEPTH);
  localparam logic [PTR_SIZE:0] LvlAf    = (PTR_SIZE + 1)'(AF_THRESH);
  localparam logic [PTR_SIZE:0] LvlAe    = (PTR_SIZE + 1)'(AE_THRESH);

  logic [PTR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE:0]     level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty        = (level_q == '0);
  assign full         = (level_q == LvlDepth);
  assign almost_full  = (level_q >= LvlAf);
  assign almost_empty = (level_q <= LvlAe);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // Flush swallows both requests, so neither can raise an error flag.
    rd_acc      = read_en && !empty && !flush;
    wr_acc      = write_en && (!full || rd_acc) && !flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = (write_en && full && !rd_acc && !flush) || (overflow_q && !clear_err);
    underflow_d = (read_en && empty && !flush) || (underflow_q && !clear_err);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_acc && !rd_acc) begin
        level_d = level_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_SIZE  (PTR_SIZE)
  ) u_mem (
    .clk       (clk),
    .write_en  (wr_acc),
    .write_addr(wr_ptr_q),
    .write_data(data_in),
    .read_addr (rd_ptr_q),
    .read_data (rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_out   = rd_data;
    assign data_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_out_q   <= '0;
        data_valid_q <= 1'b0;
      end else begin
        data_valid_q <= rd_acc;
        if (rd_acc) data_out_q <= rd_data;
      end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
  end

endmodule
